// File: rtl/instr_fetch_unit.sv
// Fetch stage: imem req/ack read into an instruction register, handed to decode via valid/ready.
// Optional request timeout with fetch_timeout pulse is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned PC_WIDTH       = 8,
  parameter int unsigned INSTR_WIDTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic                   enable_increment,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ack,
  input  logic                   flush,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [15:0]            fetch_count
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                   fetch_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 5-bit wait counter (1..31)");
  end

  state_t                 state_q, state_d;
  logic                   drop_q, drop_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;
  logic [15:0]            fetch_count_q, fetch_count_d;
  logic                   inc_raw;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LIM = 5'(TIMEOUT_CYCLES);
  logic [4:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    inc_raw       = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (flush || drop_q) begin
            drop_d  = 1'b0;
            state_d = run ? REQ : IDLE;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            inc_raw    = 1'b1;
            state_d    = VALID;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      VALID: begin
        if (flush) begin
          state_d = run ? REQ : IDLE;
        end else if (instr_ready) begin
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = run ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    wait_d    = wait_q;
    timeout_d = 1'b0;
    if (state_q == REQ && !imem_ack && wait_q != TIMEOUT_LIM) begin
      wait_d = wait_q + 5'd1;
      if (wait_q + 5'd1 == TIMEOUT_LIM) begin
        drop_d    = 1'b1;
        timeout_d = 1'b1;
      end
    end
    // Any (re)entry into REQ, including a reissue after a discarded ack, restarts the wait.
    if (state_d == REQ && (state_q != REQ || imem_ack)) wait_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      drop_q        <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_q        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
`ifdef FETCH_TIMEOUT_EN
      wait_q        <= wait_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  // Reset is synchronous, so gate the combinational outputs while it is held.
  assign enable_increment = inc_raw && !reset;
  assign imem_req         = (state_q == REQ) && !reset;
  assign imem_addr        = pc;
  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign instr_valid      = (state_q == VALID);
  assign fetch_count      = fetch_count_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_timeout    = timeout_q;
`endif

endmodule
